// File: rtl/bias_apply.sv
// rtl/bias_apply.sv - lane-wise bias add over N buffered rows; optional ReLU stage under BIAS_APPLY_RELU_EN
module bias_apply #(
  parameter int BIAS_INST_LENGTH   = 96,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_BUF_ADDR_WIDTH   = 9
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic [BIAS_INST_LENGTH-1:0]   ctrl_instruction,
  output logic                          bias_read_buffer_a_valid,
  output logic [C_BUF_ADDR_WIDTH-1:0]   bias_read_buffer_a_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] bias_read_buffer_a_data,
  output logic                          src_read_valid,
  output logic [C_BUF_ADDR_WIDTH-1:0]   src_read_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] src_read_data,
  output logic                          dst_write_valid,
  output logic [C_BUF_ADDR_WIDTH-1:0]   dst_write_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] dst_write_data
);

  localparam int LANES = C_M_AXI_DATA_WIDTH / C_ADDER_BIT_WIDTH;
  localparam int AW    = C_BUF_ADDR_WIDTH;
  localparam int LW    = C_ADDER_BIT_WIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]                    state;
  logic [AW-1:0]                 n_q;
  logic [AW-1:0]                 issue_cnt;
  logic [AW-1:0]                 dst_ptr;
  logic                          bias_pend;   // bias RAM data is on the bus this cycle
  logic                          rd_pend;     // source RAM data is on the bus this cycle
  logic [C_M_AXI_DATA_WIDTH-1:0] bias_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] sum_word;
  logic [LW-1:0]                 lane;
`ifdef BIAS_APPLY_RELU_EN
  logic                          relu_q;
`endif

  // Fields outside the used slices are intentionally dropped.
  logic unused_instr_bits;
  assign unused_instr_bits = ^ctrl_instruction;

  // Per-lane wrapped add of incoming source row and held bias, with optional clamp of negatives
  always_comb begin
    sum_word = '0;
    lane     = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = src_read_data[i*LW +: LW] + bias_q[i*LW +: LW];
`ifdef BIAS_APPLY_RELU_EN
      if (relu_q && lane[LW-1]) lane = '0;
`endif
      sum_word[i*LW +: LW] = lane;
    end
  end

  // Control FSM, read issue, and the registered write stage
  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      state                    <= S_IDLE;
      ap_done                  <= 1'b1;
      n_q                      <= '0;
      issue_cnt                <= '0;
      dst_ptr                  <= '0;
      bias_pend                <= 1'b0;
      rd_pend                  <= 1'b0;
      bias_q                   <= '0;
      bias_read_buffer_a_valid <= 1'b0;
      bias_read_buffer_a_addr  <= '0;
      src_read_valid           <= 1'b0;
      src_read_addr            <= '0;
      dst_write_valid          <= 1'b0;
      dst_write_addr           <= '0;
      dst_write_data           <= '0;
`ifdef BIAS_APPLY_RELU_EN
      relu_q                   <= 1'b0;
`endif
    end else begin
      ap_done                  <= 1'b0;
      bias_read_buffer_a_valid <= 1'b0;
      bias_pend                <= bias_read_buffer_a_valid;
      rd_pend                  <= src_read_valid;
      dst_write_valid          <= rd_pend;
      if (bias_pend) bias_q <= bias_read_buffer_a_data;
      if (rd_pend) begin
        dst_write_addr <= dst_ptr;
        dst_write_data <= sum_word;
        dst_ptr        <= dst_ptr + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (ap_start) begin
            state                    <= S_DECODE;
            bias_read_buffer_a_valid <= 1'b1;
            bias_read_buffer_a_addr  <= ctrl_instruction[32 +: AW];
            n_q                      <= ctrl_instruction[48 +: AW];
            src_read_addr            <= ctrl_instruction[64 +: AW];
            dst_ptr                  <= ctrl_instruction[80 +: AW];
            issue_cnt                <= '0;
`ifdef BIAS_APPLY_RELU_EN
            relu_q                   <= ctrl_instruction[16];
`endif
          end
        end
        S_DECODE: begin
          if (n_q == '0) begin
            state   <= S_DONE;
            ap_done <= 1'b1;
          end else begin
            state          <= S_RUN;
            src_read_valid <= 1'b1;
          end
        end
        S_RUN: begin
          if (issue_cnt == n_q - 1'b1) begin
            state          <= S_DRAIN;
            src_read_valid <= 1'b0;
          end else begin
            issue_cnt     <= issue_cnt + 1'b1;
            src_read_addr <= src_read_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          // rd_pend low means the final row has reached the write register
          if (!rd_pend) begin
            state   <= S_DONE;
            ap_done <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bias_apply.sv
// tb/tb_bias_apply.sv - self-checking bench for bias_apply
`timescale 1ns/1ps
module tb_bias_apply;

  localparam int DW    = 512;
  localparam int AW    = 9;
  localparam int LANES = 16;
  localparam int DEPTH = 512;

`ifdef BIAS_APPLY_RELU_EN
  localparam bit RELU_BUILT = 1'b1;
`else
  localparam bit RELU_BUILT = 1'b0;
`endif

  logic          kernel_clk = 1'b0;
  logic          kernel_rst = 1'b1;
  logic          ap_start   = 1'b0;
  logic          ap_done;
  logic [95:0]   ctrl_instruction = '0;
  logic          bias_read_buffer_a_valid;
  logic [AW-1:0] bias_read_buffer_a_addr;
  logic [DW-1:0] bias_read_buffer_a_data = '0;
  logic          src_read_valid;
  logic [AW-1:0] src_read_addr;
  logic [DW-1:0] src_read_data = '0;
  logic          dst_write_valid;
  logic [AW-1:0] dst_write_addr;
  logic [DW-1:0] dst_write_data;

  always #5 kernel_clk = ~kernel_clk;

  bias_apply dut (
    .kernel_clk               (kernel_clk),
    .kernel_rst               (kernel_rst),
    .ap_start                 (ap_start),
    .ap_done                  (ap_done),
    .ctrl_instruction         (ctrl_instruction),
    .bias_read_buffer_a_valid (bias_read_buffer_a_valid),
    .bias_read_buffer_a_addr  (bias_read_buffer_a_addr),
    .bias_read_buffer_a_data  (bias_read_buffer_a_data),
    .src_read_valid           (src_read_valid),
    .src_read_addr            (src_read_addr),
    .src_read_data            (src_read_data),
    .dst_write_valid          (dst_write_valid),
    .dst_write_addr           (dst_write_addr),
    .dst_write_data           (dst_write_data)
  );

  logic [DW-1:0] bias_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [DW-1:0] snap     [DEPTH];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;
  ev_t bq[$];
  ev_t sq[$];
  ev_t wq[$];
  int  dq[$];

  typedef struct {
    int          src;
    int          dst;
    int          baddr;
    int          n;
    bit          relu;
    int          pat;
    logic [31:0] exp_lane0;
    int          exp_done_off;
  } vec_t;

  // cycle counter and 1-cycle-latency RAM read ports
  always @(posedge kernel_clk) begin
    cyc <= cyc + 1;
    if (bias_read_buffer_a_valid) bias_read_buffer_a_data <= bias_mem[bias_read_buffer_a_addr];
    if (src_read_valid) src_read_data <= data_mem[src_read_addr];
  end

  // event log sampled mid-cycle
  always @(negedge kernel_clk) begin
    if (bias_read_buffer_a_valid) bq.push_back('{cyc: cyc, addr: bias_read_buffer_a_addr, data: '0});
    if (src_read_valid) sq.push_back('{cyc: cyc, addr: src_read_addr, data: '0});
    if (dst_write_valid) wq.push_back('{cyc: cyc, addr: dst_write_addr, data: dst_write_data});
    if (ap_done) dq.push_back(cyc);
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference: 32-bit lanes added as plain integers, reduced mod 2^32, negatives clamped when ReLU active
  function automatic logic [DW-1:0] expect_row(input logic [DW-1:0] s, input logic [DW-1:0] b, input bit relu);
    logic [DW-1:0] r;
    longint unsigned x;
    longint unsigned y;
    longint unsigned sum;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      x   = s[i*32 +: 32];
      y   = b[i*32 +: 32];
      sum = (x + y) % 64'h1_0000_0000;
      if (relu && RELU_BUILT && sum >= 64'h8000_0000) sum = 0;
      r[i*32 +: 32] = sum[31:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < LANES; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic step();
    @(negedge kernel_clk);
    #1;
  endtask

  task automatic issue(input int src, input int dst, input int baddr, input int n, input bit relu, output int t);
    ctrl_instruction        = '0;
    ctrl_instruction[16]    = relu;
    ctrl_instruction[47:32] = baddr[15:0];
    ctrl_instruction[63:48] = n[15:0];
    ctrl_instruction[79:64] = src[15:0];
    ctrl_instruction[95:80] = dst[15:0];
    snap     = data_mem;
    ap_start = 1'b1;
    t        = cyc;
    step();
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int d);
    d = -1;
    for (int k = 0; k < 2000; k++) begin
      if (ap_done === 1'b1) begin
        d = cyc;
        break;
      end
      step();
    end
    if (d < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout actual=none required=ap_done", tag);
    end
  endtask

  // commit the logged writes of one instruction into the data buffer model
  task automatic apply_writes(input int lo, input int hi);
    foreach (wq[i]) if (wq[i].cyc >= lo && wq[i].cyc <= hi) data_mem[wq[i].addr] = wq[i].data;
  endtask

  task automatic check_instr(input int t, input int src_f, input int dst_f, input int baddr_f,
                             input int n_f, input bit relu, input string tag);
    int src, dst, baddr, n, lo, hi, cnt;
    src   = src_f % DEPTH;
    dst   = dst_f % DEPTH;
    baddr = baddr_f % DEPTH;
    n     = n_f % DEPTH;
    lo    = t + 1;
    hi    = (n == 0) ? t + 2 : t + 4 + n;
    cnt = 0;
    foreach (bq[i]) if (bq[i].cyc >= lo && bq[i].cyc <= hi) begin
      check({tag, "_bias_cyc"}, bq[i].cyc, t + 1);
      check({tag, "_bias_addr"}, bq[i].addr, baddr);
      cnt++;
    end
    check({tag, "_bias_count"}, cnt, 1);
    cnt = 0;
    foreach (sq[i]) if (sq[i].cyc >= lo && sq[i].cyc <= hi) begin
      check({tag, "_src_cyc"}, sq[i].cyc, t + 2 + cnt);
      check({tag, "_src_addr"}, sq[i].addr, (src + cnt) % DEPTH);
      cnt++;
    end
    check({tag, "_src_count"}, cnt, n);
    cnt = 0;
    foreach (wq[i]) if (wq[i].cyc >= lo && wq[i].cyc <= hi) begin
      check({tag, "_wr_cyc"}, wq[i].cyc, t + 4 + cnt);
      check({tag, "_wr_addr"}, wq[i].addr, (dst + cnt) % DEPTH);
      check({tag, "_wr_data"}, wq[i].data, expect_row(snap[(src + cnt) % DEPTH], bias_mem[baddr], relu));
      cnt++;
    end
    check({tag, "_wr_count"}, cnt, n);
    cnt = 0;
    foreach (dq[i]) if (dq[i] >= lo && dq[i] <= hi) begin
      check({tag, "_done_cyc"}, dq[i], hi);
      cnt++;
    end
    check({tag, "_done_count"}, cnt, 1);
  endtask

  task automatic fill(input int pat, input int src, input int baddr, input int n);
    logic [DW-1:0] b, s;
    for (int i = 0; i < LANES; i++) begin
      case (pat)
        0: begin b[i*32 +: 32] = i + 1; s[i*32 +: 32] = 100; end
        1: begin
          b[i*32 +: 32] = (i == 0) ? 32'h1 : i * 7;
          s[i*32 +: 32] = (i == 0) ? 32'hFFFF_FFFF : 1000 + i;
        end
        default: begin b[i*32 +: 32] = 32'hFFFF_FFFB; s[i*32 +: 32] = (i % 2 == 1) ? 10 : 3; end
      endcase
    end
    bias_mem[baddr % DEPTH] = b;
    for (int k = 0; k < n % DEPTH; k++) data_mem[(src + k) % DEPTH] = s;
  endtask

  initial begin
    vec_t vecs[6];
    int t, d, t2, d2, cnt;
    logic [31:0] lane0;
    logic [DW-1:0] orig, bword;

    vecs[0] = '{0,        64,       3,        4,        1'b0, 0, 32'd101, 8};
    vecs[1] = '{510,      511,      7,        4,        1'b0, 1, 32'h0,   8};
    vecs[2] = '{20,       100,      9,        6,        1'b1, 2, (RELU_BUILT ? 32'h0 : 32'hFFFF_FFFE), 10};
    vecs[3] = '{20,       100,      9,        6,        1'b0, 2, 32'hFFFF_FFFE, 10};
    vecs[4] = '{30,       40,       11,       0,        1'b1, 0, 32'h0,   2};
    vecs[5] = '{16'hFE05, 16'h0282, 16'hFE03, 16'hFE03, 1'b0, 0, 32'd101, 7};

    for (int i = 0; i < DEPTH; i++) begin
      bias_mem[i] = rand_word();
      data_mem[i] = rand_word();
    end

    // reset state
    repeat (3) step();
    check("rst_ap_done", ap_done, 1);
    check("rst_bias_valid", bias_read_buffer_a_valid, 0);
    check("rst_src_valid", src_read_valid, 0);
    check("rst_dst_valid", dst_write_valid, 0);
    check("rst_dst_data", dst_write_data, 0);
    check("rst_addrs", {bias_read_buffer_a_addr, src_read_addr, dst_write_addr}, 0);
    kernel_rst = 1'b0;
    step();
    check("post_rst_ap_done", ap_done, 0);
    step();

    // table-driven directed vectors
    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].pat, vecs[v].src, vecs[v].baddr, vecs[v].n);
      issue(vecs[v].src, vecs[v].dst, vecs[v].baddr, vecs[v].n, vecs[v].relu, t);
      wait_done($sformatf("vec%0d", v), d);
      apply_writes(t + 1, d);
      check_instr(t, vecs[v].src, vecs[v].dst, vecs[v].baddr, vecs[v].n, vecs[v].relu, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_done_latency", v), d - t, vecs[v].exp_done_off);
      if (vecs[v].n % DEPTH != 0) begin
        lane0 = 32'hDEAD_BEEF;
        foreach (wq[i]) if (wq[i].cyc == t + 4) lane0 = wq[i].data[31:0];
        check($sformatf("vec%0d_first_lane0", v), lane0, vecs[v].exp_lane0);
      end
      repeat (2) step();
    end

    // in-place, ignored mid-run start, back-to-back start
    orig  = data_mem[10];
    bword = bias_mem[20];
    issue(10, 10, 20, 8, 1'b0, t);
    repeat (3) step();
    ctrl_instruction        = '0;
    ctrl_instruction[63:48] = 16'd3;
    ctrl_instruction[95:80] = 16'd200;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    wait_done("inplace1", d);
    apply_writes(t + 1, d);
    check_instr(t, 10, 10, 20, 8, 1'b0, "inplace1");
    step();
    issue(10, 10, 20, 8, 1'b0, t2);
    check("b2b_start_cycle", t2, d + 1);
    wait_done("inplace2", d2);
    apply_writes(t2 + 1, d2);
    check_instr(t2, 10, 10, 20, 8, 1'b0, "inplace2");
    check("inplace_row10_twice", data_mem[10], expect_row(expect_row(orig, bword, 1'b0), bword, 1'b0));
    cnt = 0;
    foreach (wq[i]) if (wq[i].addr == 9'd200) cnt++;
    check("decoy_no_writes", cnt, 0);
    repeat (2) step();

    // reset during RUN at k=3
    issue(50, 300, 1, 10, 1'b0, t);
    repeat (4) step();
    check("midrst_src_k3_addr", src_read_addr, 53);
    kernel_rst = 1'b1;
    step();
    check("midrst_ap_done_high", ap_done, 1);
    check("midrst_src_valid", src_read_valid, 0);
    check("midrst_dst_valid", dst_write_valid, 0);
    kernel_rst = 1'b0;
    step();
    check("midrst_ap_done_low", ap_done, 0);
    repeat (12) step();
    cnt = 0;
    foreach (sq[i]) if (sq[i].cyc >= t + 6) cnt++;
    foreach (wq[i]) if (wq[i].cyc >= t + 6) cnt++;
    check("midrst_no_activity_after", cnt, 0);
    cnt = 0;
    foreach (wq[i]) if (wq[i].cyc > t && wq[i].cyc < t + 6) cnt++;
    check("midrst_writes_before", cnt, 2);
    fill(0, 60, 2, 5);
    issue(60, 70, 2, 5, 1'b0, t);
    wait_done("after_rst", d);
    apply_writes(t + 1, d);
    check_instr(t, 60, 70, 2, 5, 1'b0, "after_rst");
    repeat (2) step();

    // randomized instructions against the reference model
    for (int r = 0; r < 20; r++) begin
      int rs, rd, rb, rn;
      bit rr;
      rs = $urandom_range(0, 511);
      rd = $urandom_range(0, 511);
      rb = $urandom_range(0, 511);
      rn = $urandom_range(0, 12);
      rr = 1'($urandom_range(0, 1));
      bias_mem[rb] = rand_word();
      for (int k = 0; k < rn; k++) data_mem[(rs + k) % DEPTH] = rand_word();
      issue(rs, rd, rb, rn, rr, t);
      wait_done($sformatf("rnd%0d", r), d);
      apply_writes(t + 1, d);
      check_instr(t, rs, rd, rb, rn, rr, $sformatf("rnd%0d", r));
      repeat ($urandom_range(1, 3)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
